// File: rtl/ppu_vram_writer.sv
// Host-side loader for PPU tile/pattern RAM port B: turns a 32-bit header+payload
// stream into gated 64-bit writes, only while the vblank/prep window allows them.
module ppu_vram_writer #(
  parameter int TIL_AW = 11,
  parameter int PAT_AW = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [31:0]       cmd_data,
  input  logic              wr_allow,
  output logic [TIL_AW-1:0] tilram_addr_b,
  output logic [63:0]       tilram_data_b,
  output logic [7:0]        tilram_byteena_b,
  output logic              tilram_wren_b,
  output logic [PAT_AW-1:0] patram_addr_b,
  output logic [63:0]       patram_data_b,
  output logic [7:0]        patram_byteena_b,
  output logic              patram_wren_b,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int AW = (TIL_AW > PAT_AW) ? TIL_AW : PAT_AW;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LO   = 3'd1;
  localparam logic [2:0] S_HI   = 3'd2;
  localparam logic [2:0] S_WR   = 3'd3;
  localparam logic [2:0] S_DISC = 3'd4;

  logic [2:0]    state;
  logic          tgt_pat;
  logic [AW-1:0] addr;
  logic [11:0]   cnt;
  logic [12:0]   disc_cnt;
  logic [31:0]   lo_word;
  logic [63:0]   wdata;

  logic          accept;
  logic          wren_any;
  logic          issue;
  logic [63:0]   issue_data;
  logic [11:0]   hdr_n;

  assign cmd_ready = !rst && (state != S_WR);
  assign accept    = cmd_valid && cmd_ready;
  assign busy      = (state != S_IDLE);
  assign wren_any  = tilram_wren_b | patram_wren_b;
  assign hdr_n     = cmd_data[11:0];

  // A write is launched straight from the HI acceptance when the window is open,
  // otherwise from WR once it opens; wren is registered, so it appears one cycle later.
  assign issue      = wr_allow && ((state == S_HI && accept) || (state == S_WR && !wren_any));
  assign issue_data = (state == S_HI) ? {cmd_data, lo_word} : wdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= S_IDLE;
      tgt_pat          <= 1'b0;
      addr             <= '0;
      cnt              <= '0;
      disc_cnt         <= '0;
      lo_word          <= '0;
      wdata            <= '0;
      tilram_addr_b    <= '0;
      tilram_data_b    <= '0;
      tilram_byteena_b <= '0;
      tilram_wren_b    <= 1'b0;
      patram_addr_b    <= '0;
      patram_data_b    <= '0;
      patram_byteena_b <= '0;
      patram_wren_b    <= 1'b0;
      done             <= 1'b0;
      err              <= 1'b0;
    end else begin
      done             <= 1'b0;
      err              <= 1'b0;
      tilram_wren_b    <= 1'b0;
      patram_wren_b    <= 1'b0;
      tilram_byteena_b <= '0;
      patram_byteena_b <= '0;

      case (state)
        S_IDLE: if (accept) begin
          if (cmd_data[31]) begin
            err <= 1'b1;
            if (hdr_n == 12'd0) done <= 1'b1;
            else begin
              disc_cnt <= {hdr_n, 1'b0};
              state    <= S_DISC;
            end
          end else if (hdr_n == 12'd0) begin
            done <= 1'b1;
          end else begin
            tgt_pat <= cmd_data[30];
            addr    <= AW'(cmd_data[29:18]);
            cnt     <= hdr_n;
            state   <= S_LO;
          end
        end
        S_LO: if (accept) begin
          lo_word <= cmd_data;
          state   <= S_HI;
        end
        S_HI: if (accept) begin
          wdata <= {cmd_data, lo_word};
          state <= S_WR;
        end
        // Count was already decremented when the write launched.
        S_WR: if (wren_any) state <= (cnt == 12'd0) ? S_IDLE : S_LO;
        S_DISC: if (accept) begin
          disc_cnt <= disc_cnt - 13'd1;
          if (disc_cnt == 13'd1) begin
            state <= S_IDLE;
            done  <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase

      if (issue) begin
        if (tgt_pat) begin
          patram_addr_b    <= addr[PAT_AW-1:0];
          patram_data_b    <= issue_data;
          patram_byteena_b <= 8'hFF;
          patram_wren_b    <= 1'b1;
        end else begin
          tilram_addr_b    <= addr[TIL_AW-1:0];
          tilram_data_b    <= issue_data;
          tilram_byteena_b <= 8'hFF;
          tilram_wren_b    <= 1'b1;
        end
        addr <= addr + AW'(1);
        cnt  <= cnt - 12'd1;
        if (cnt == 12'd1) done <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ppu_vram_writer.sv
// Directed bench for ppu_vram_writer: inputs change on the falling edge,
// outputs are observed on the falling edge after each rising edge.
module tb_ppu_vram_writer;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_data;
  logic        wr_allow;
  logic [10:0] tilram_addr_b;
  logic [63:0] tilram_data_b;
  logic [7:0]  tilram_byteena_b;
  logic        tilram_wren_b;
  logic [11:0] patram_addr_b;
  logic [63:0] patram_data_b;
  logic [7:0]  patram_byteena_b;
  logic        patram_wren_b;
  logic        busy;
  logic        done;
  logic        err;

  int checks = 0;
  int failures = 0;

  ppu_vram_writer #(.TIL_AW(11), .PAT_AW(12)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data),
    .wr_allow(wr_allow),
    .tilram_addr_b(tilram_addr_b), .tilram_data_b(tilram_data_b),
    .tilram_byteena_b(tilram_byteena_b), .tilram_wren_b(tilram_wren_b),
    .patram_addr_b(patram_addr_b), .patram_data_b(patram_data_b),
    .patram_byteena_b(patram_byteena_b), .patram_wren_b(patram_wren_b),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // write/pulse log captured on every falling edge
  int          cyc = 0;
  logic [10:0] t_addr_q[$];
  logic [63:0] t_data_q[$];
  logic [7:0]  t_be_q[$];
  int          t_cyc_q[$];
  logic [11:0] p_addr_q[$];
  logic [63:0] p_data_q[$];
  logic [7:0]  p_be_q[$];
  int          done_cnt = 0;
  int          done_cyc = -1;
  int          err_cnt = 0;
  int          busy_seen = 0;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (tilram_wren_b) begin
      t_addr_q.push_back(tilram_addr_b);
      t_data_q.push_back(tilram_data_b);
      t_be_q.push_back(tilram_byteena_b);
      t_cyc_q.push_back(cyc);
    end
    if (patram_wren_b) begin
      p_addr_q.push_back(patram_addr_b);
      p_data_q.push_back(patram_data_b);
      p_be_q.push_back(patram_byteena_b);
    end
    if (done) begin done_cnt = done_cnt + 1; done_cyc = cyc; end
    if (err) err_cnt = err_cnt + 1;
    if (busy) busy_seen = busy_seen + 1;
  end

  task automatic clear_log();
    t_addr_q.delete(); t_data_q.delete(); t_be_q.delete(); t_cyc_q.delete();
    p_addr_q.delete(); p_data_q.delete(); p_be_q.delete();
    done_cnt = 0; done_cyc = -1; err_cnt = 0; busy_seen = 0;
  endtask

  // Called at a falling edge; returns at the falling edge after acceptance.
  task automatic send(input logic [31:0] w);
    int guard = 0;
    cmd_valid = 1'b1;
    cmd_data  = w;
    while (!cmd_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) begin
      checks++; failures++;
      $display("FAIL send_timeout word=%h cmd_ready stayed low", w);
    end
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int guard = 0;
    while (busy && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL %s_idle_timeout busy=%b expected 0", name, busy);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; cmd_valid = 1'b0; cmd_data = '0; wr_allow = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({cmd_ready, busy, done, err, tilram_wren_b, patram_wren_b} !== 6'b0) begin
      failures++;
      $display("FAIL reset_ctrl got rdy=%b busy=%b done=%b err=%b tw=%b pw=%b expected all 0",
               cmd_ready, busy, done, err, tilram_wren_b, patram_wren_b);
    end
    checks++;
    if ({tilram_addr_b, tilram_data_b, tilram_byteena_b, patram_addr_b, patram_data_b, patram_byteena_b} !== '0) begin
      failures++;
      $display("FAIL reset_data got ta=%h td=%h tb=%h pa=%h pd=%h pb=%h expected 0",
               tilram_addr_b, tilram_data_b, tilram_byteena_b, patram_addr_b, patram_data_b, patram_byteena_b);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready got %b expected 1", cmd_ready);
    end
  endtask

  task automatic test_tile_basic();
    clear_log();
    wr_allow = 1'b1;
    send(32'h0028_0002);
    send(32'h1111_1111); send(32'h2222_2222);
    send(32'h3333_3333); send(32'h4444_4444);
    wait_idle("tile_basic");
    checks++;
    if (t_addr_q.size() != 2 || p_addr_q.size() != 0) begin
      failures++;
      $display("FAIL tile_count got tile=%0d pat=%0d expected 2/0", t_addr_q.size(), p_addr_q.size());
    end else begin
      checks++;
      if (t_addr_q[0] !== 11'h00A || t_data_q[0] !== 64'h2222_2222_1111_1111 || t_be_q[0] !== 8'hFF) begin
        failures++;
        $display("FAIL tile_w0 got a=%h d=%h be=%h expected 00a 2222222211111111 ff", t_addr_q[0], t_data_q[0], t_be_q[0]);
      end
      checks++;
      if (t_addr_q[1] !== 11'h00B || t_data_q[1] !== 64'h4444_4444_3333_3333 || t_be_q[1] !== 8'hFF) begin
        failures++;
        $display("FAIL tile_w1 got a=%h d=%h be=%h expected 00b 4444444433333333 ff", t_addr_q[1], t_data_q[1], t_be_q[1]);
      end
      checks++;
      if (t_cyc_q[1] - t_cyc_q[0] != 3) begin
        failures++;
        $display("FAIL tile_throughput got spacing %0d expected 3", t_cyc_q[1] - t_cyc_q[0]);
      end
      checks++;
      if (done_cnt != 1 || done_cyc != t_cyc_q[1]) begin
        failures++;
        $display("FAIL tile_done got cnt=%0d cyc=%0d expected 1 at %0d", done_cnt, done_cyc, t_cyc_q[1]);
      end
    end
    checks++;
    if (tilram_byteena_b !== 8'h00 || tilram_data_b !== 64'h4444_4444_3333_3333) begin
      failures++;
      $display("FAIL tile_hold got be=%h d=%h expected 00 4444444433333333", tilram_byteena_b, tilram_data_b);
    end
  endtask

  task automatic test_pat_wrap();
    clear_log();
    wr_allow = 1'b1;
    send(32'h7FFC_0002);
    send(32'hDEAD_BEEF); send(32'h0123_4567);
    send(32'hCAFE_F00D); send(32'h89AB_CDEF);
    wait_idle("pat_wrap");
    checks++;
    if (p_addr_q.size() != 2 || t_addr_q.size() != 0) begin
      failures++;
      $display("FAIL pat_count got pat=%0d tile=%0d expected 2/0", p_addr_q.size(), t_addr_q.size());
    end else begin
      checks++;
      if (p_addr_q[0] !== 12'hFFF || p_data_q[0] !== 64'h0123_4567_DEAD_BEEF || p_be_q[0] !== 8'hFF) begin
        failures++;
        $display("FAIL pat_w0 got a=%h d=%h be=%h expected fff 01234567deadbeef ff", p_addr_q[0], p_data_q[0], p_be_q[0]);
      end
      checks++;
      if (p_addr_q[1] !== 12'h000 || p_data_q[1] !== 64'h89AB_CDEF_CAFE_F00D || p_be_q[1] !== 8'hFF) begin
        failures++;
        $display("FAIL pat_w1 got a=%h d=%h be=%h expected 000 89abcdefcafef00d ff", p_addr_q[1], p_data_q[1], p_be_q[1]);
      end
    end
  endtask

  task automatic test_wr_gate();
    int bad = 0;
    clear_log();
    wr_allow = 1'b0;
    send(32'h0014_0001);
    send(32'h5555_AAAA); send(32'h0F0F_F0F0);
    for (int i = 0; i < 20; i++) begin
      if (tilram_wren_b || patram_wren_b || cmd_ready !== 1'b0) bad++;
      @(negedge clk);
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL gate_hold got %0d bad cycles expected 0", bad);
    end
    wr_allow = 1'b1;
    @(negedge clk);
    checks++;
    if (tilram_wren_b !== 1'b1 || tilram_addr_b !== 11'h005 || tilram_data_b !== 64'h0F0F_F0F0_5555_AAAA || done !== 1'b1) begin
      failures++;
      $display("FAIL gate_write got wren=%b a=%h d=%h done=%b expected 1 005 0f0ff0f05555aaaa 1",
               tilram_wren_b, tilram_addr_b, tilram_data_b, done);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || tilram_wren_b !== 1'b0) begin
      failures++;
      $display("FAIL gate_after got busy=%b wren=%b expected 0 0", busy, tilram_wren_b);
    end
  endtask

  task automatic test_invalid();
    clear_log();
    wr_allow = 1'b1;
    send(32'h8000_0003);
    checks++;
    if (err !== 1'b1 || busy !== 1'b1) begin
      failures++;
      $display("FAIL inv_err got err=%b busy=%b expected 1 1", err, busy);
    end
    for (int i = 0; i < 5; i++) send(32'h1000_0000 + i);
    checks++;
    if (done_cnt != 0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL inv_early got done_cnt=%0d busy=%b expected 0 1", done_cnt, busy);
    end
    send(32'h1000_0005);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL inv_done got done=%b busy=%b expected 1 0", done, busy);
    end
    @(negedge clk);
    checks++;
    if (t_addr_q.size() != 0 || p_addr_q.size() != 0 || err_cnt != 1) begin
      failures++;
      $display("FAIL inv_nowrite got tile=%0d pat=%0d errs=%0d expected 0 0 1", t_addr_q.size(), p_addr_q.size(), err_cnt);
    end
  endtask

  task automatic test_zero_count();
    clear_log();
    send(32'h0028_0000);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || err !== 1'b0) begin
      failures++;
      $display("FAIL zero_done got done=%b busy=%b err=%b expected 1 0 0", done, busy, err);
    end
    @(negedge clk);
    send(32'hC000_0000);
    checks++;
    if (done !== 1'b1 || err !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL zero_inv got done=%b err=%b busy=%b expected 1 1 0", done, err, busy);
    end
    @(negedge clk);
    checks++;
    if (busy_seen != 0 || done_cnt != 2 || t_addr_q.size() != 0 || p_addr_q.size() != 0) begin
      failures++;
      $display("FAIL zero_quiet got busy_seen=%0d dones=%0d writes=%0d expected 0 2 0",
               busy_seen, done_cnt, t_addr_q.size() + p_addr_q.size());
    end
  endtask

  task automatic test_reset_mid();
    clear_log();
    wr_allow = 1'b1;
    send(32'h0040_0002);
    send(32'h7777_7777);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b0 || busy !== 1'b0 || tilram_wren_b !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_in got rdy=%b busy=%b wren=%b expected 0 0 0", cmd_ready, busy, tilram_wren_b);
    end
    rst = 1'b0;
    @(negedge clk);
    send(32'h0040_0001);
    send(32'hAAAA_AAAA); send(32'hBBBB_BBBB);
    wait_idle("rst_mid");
    checks++;
    if (t_addr_q.size() != 1 || p_addr_q.size() != 0) begin
      failures++;
      $display("FAIL rstmid_count got tile=%0d pat=%0d expected 1 0", t_addr_q.size(), p_addr_q.size());
    end else begin
      checks++;
      if (t_addr_q[0] !== 11'h010 || t_data_q[0] !== 64'hBBBB_BBBB_AAAA_AAAA) begin
        failures++;
        $display("FAIL rstmid_write got a=%h d=%h expected 010 bbbbbbbbaaaaaaaa", t_addr_q[0], t_data_q[0]);
      end
    end
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_data = '0; wr_allow = 1'b0;
    @(negedge clk);
    test_reset();
    test_tile_basic();
    test_pat_wrap();
    test_wr_gate();
    test_invalid();
    test_zero_count();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
